// File: rtl/hazard_fwd_unit_if.sv
// Hazard/forwarding unit signal bundle: the pipeline (master) presents register
// addresses and EX control, the hazard unit (slave) returns forwarding selects and stall/flush commands.
interface hazard_fwd_unit_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] ID_RA1;
  logic [REG_AW-1:0] ID_RA2;
  logic              ID_USE_RS1;
  logic              ID_USE_RS2;
  logic [REG_AW-1:0] EX_RA1;
  logic [REG_AW-1:0] EX_RA2;
  logic [REG_AW-1:0] EX_WA;
  logic              EX_RF_WE;
  logic              EX_MEMREAD;
  logic              EX_TAKEN;
  logic [1:0]        FWD_A;
  logic [1:0]        FWD_B;
  logic              STALL_PC;
  logic              STALL_IFID;
  logic              BUBBLE_IDEX;
  logic              FLUSH_IFID;
  logic              FLUSH_IDEX;
  logic [31:0]       STALL_CNT;
  logic [31:0]       FLUSH_CNT;

  modport master (
    output ID_RA1, ID_RA2, ID_USE_RS1, ID_USE_RS2,
    output EX_RA1, EX_RA2, EX_WA, EX_RF_WE, EX_MEMREAD, EX_TAKEN,
    input  FWD_A, FWD_B, STALL_PC, STALL_IFID, BUBBLE_IDEX,
    input  FLUSH_IFID, FLUSH_IDEX, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RA1, ID_RA2, ID_USE_RS1, ID_USE_RS2,
    input  EX_RA1, EX_RA2, EX_WA, EX_RF_WE, EX_MEMREAD, EX_TAKEN,
    output FWD_A, FWD_B, STALL_PC, STALL_IFID, BUBBLE_IDEX,
    output FLUSH_IFID, FLUSH_IDEX, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// RV32I hazard detection and operand forwarding unit, clocked on negedge with the pipeline registers.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_fwd_unit #(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  hazard_fwd_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_LU_STALL = 2'd1, S_REDIRECT = 2'd2} state_t;

  localparam logic [1:0] LU_CNT_INIT    = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FLUSH_CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;

  logic [REG_AW-1:0] r_mem_wa;
  logic              r_mem_we;
  logic              r_mem_rd;
  logic [REG_AW-1:0] r_wb_wa;
  logic              r_wb_we;

  logic              w_lu;
  logic              w_stall;
  logic              w_flush_ifid;
  logic              w_flush_idex;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] ra,
    input logic [REG_AW-1:0] mem_wa,
    input logic              mem_we,
    input logic              mem_rd,
    input logic [REG_AW-1:0] wb_wa,
    input logic              wb_we
  );
    // A load result is not available in MEM yet, so it may only come from WB.
    if (mem_we && (mem_wa != '0) && (mem_wa == ra) && !mem_rd)
      return 2'b01;
    else if (wb_we && (wb_wa != '0) && (wb_wa == ra))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Shadow of the MEM/WB destination fields; advances even while stalled.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_mem_wa <= '0;
      r_mem_we <= 1'b0;
      r_mem_rd <= 1'b0;
      r_wb_wa  <= '0;
      r_wb_we  <= 1'b0;
    end else begin
      r_mem_wa <= bus.EX_WA;
      r_mem_we <= bus.EX_RF_WE;
      r_mem_rd <= bus.EX_MEMREAD;
      r_wb_wa  <= r_mem_wa;
      r_wb_we  <= r_mem_we;
    end
  end

  assign bus.FWD_A = fwd_sel(bus.EX_RA1, r_mem_wa, r_mem_we, r_mem_rd, r_wb_wa, r_wb_we);
  assign bus.FWD_B = fwd_sel(bus.EX_RA2, r_mem_wa, r_mem_we, r_mem_rd, r_wb_wa, r_wb_we);

  assign w_lu = bus.EX_MEMREAD && bus.EX_RF_WE && (bus.EX_WA != '0) &&
                ((bus.ID_USE_RS1 && (bus.ID_RA1 == bus.EX_WA)) ||
                 (bus.ID_USE_RS2 && (bus.ID_RA2 == bus.EX_WA)));

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (bus.EX_TAKEN) begin
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = S_REDIRECT;
            w_cnt_nxt   = FLUSH_CNT_INIT;
          end
        end else if (w_lu) begin
          if (LOAD_LAT > 1) begin
            w_state_nxt = S_LU_STALL;
            w_cnt_nxt   = LU_CNT_INIT;
          end
        end
      end
      S_LU_STALL, S_REDIRECT: begin
        if (r_cnt == 2'd1) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Commands are masked while RST is high so an aborted stall/flush drops at once.
  always_comb begin
    w_stall      = 1'b0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    if (!RST) begin
      case (r_state)
        S_RUN: begin
          if (bus.EX_TAKEN) begin
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
          end else if (w_lu) begin
            w_stall = 1'b1;
          end
        end
        S_LU_STALL: w_stall      = 1'b1;
        S_REDIRECT: w_flush_ifid = 1'b1;
        default:    w_stall      = 1'b0;
      endcase
    end
  end

  assign bus.STALL_PC    = w_stall;
  assign bus.STALL_IFID  = w_stall;
  assign bus.BUBBLE_IDEX = w_stall;
  assign bus.FLUSH_IFID  = w_flush_ifid;
  assign bus.FLUSH_IDEX  = w_flush_idex;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall)      r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_ifid) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.STALL_CNT = r_stall_cnt;
  assign bus.FLUSH_CNT = r_flush_cnt;
`else
  assign bus.STALL_CNT = 32'd0;
  assign bus.FLUSH_CNT = 32'd0;
`endif

endmodule
